// File: rtl/bounce_seq_ctrl.sv
// Step-rate sequencer for the bouncing one-hot shift register: paces sr_ena,
// counts TC rises and stops after the programmed number of bounce periods.
module bounce_seq_ctrl #(
  parameter int DIV_W = 16,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rstna,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [PER_W-1:0] cfg_periods,
  input  logic             sr_tc,
  output logic             sr_ena,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] periods_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [PER_W-1:0] ONE_P = PER_W'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [DIV_W-1:0] div_sh, div_sh_nxt, div_eff;
  logic [PER_W-1:0] per_sh, per_sh_nxt;
  logic [PER_W-1:0] cnt_nxt;
  logic             ena_nxt;
  logic             sr_tc_q;
  logic             tc_rise;

  assign tc_rise = sr_tc & ~sr_tc_q;
  assign div_eff = (div_sh == '0) ? ONE_D : div_sh;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    ena_nxt    = 1'b0;
    cnt_nxt    = periods_done;
    div_sh_nxt = div_sh;
    per_sh_nxt = per_sh;
    case (state)
      IDLE: begin
        if (start) begin
          div_sh_nxt = cfg_div;
          per_sh_nxt = cfg_periods;
          cnt_nxt    = '0;
          presc_nxt  = '0;
          state_nxt  = (cfg_periods == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          if (tc_rise && (periods_done != '1))
            cnt_nxt = periods_done + ONE_P;
          // The final TC rise ends the run before another step can be issued.
          if (tc_rise && (cnt_nxt == per_sh)) begin
            state_nxt = DONE;
          end else if (!hold) begin
            if (presc == div_eff) begin
              presc_nxt = '0;
              ena_nxt   = 1'b1;
            end else begin
              presc_nxt = presc + ONE_D;
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      state        <= IDLE;
      sr_ena       <= 1'b0;
      periods_done <= '0;
      presc        <= '0;
      sr_tc_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sr_ena       <= ena_nxt;
      periods_done <= cnt_nxt;
      presc        <= presc_nxt;
      sr_tc_q      <= sr_tc;
    end
  end

  // Shadow config is only meaningful after an accepted start, so it carries no reset.
  always_ff @(posedge clk) begin
    div_sh <= div_sh_nxt;
    per_sh <= per_sh_nxt;
  end

endmodule

// File: tb/tb_bounce_seq_ctrl.sv
// Bench for bounce_seq_ctrl: drives an 8-bit bouncing one-hot register from sr_ena
// and checks table rows, corner sequences and randomized runs against a timing model.
module tb_bounce_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstna = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [7:0]  cfg_periods = '0;
  logic        sr_tc;
  logic        sr_ena;
  logic        busy;
  logic        done;
  logic [7:0]  periods_done;

  logic        sr_clr = 1'b1;
  logic [7:0]  sr;
  logic        sr_dn;

  int n_pass = 0;
  int n_total = 0;

  bounce_seq_ctrl #(.DIV_W(16), .PER_W(8)) dut (
    .clk(clk), .rstna(rstna), .start(start), .abort(abort), .hold(hold),
    .cfg_div(cfg_div), .cfg_periods(cfg_periods), .sr_tc(sr_tc),
    .sr_ena(sr_ena), .busy(busy), .done(done), .periods_done(periods_done)
  );

  always #5 clk = ~clk;

  // Bouncing one-hot register: bit0 -> bit7 -> bit0 ..., TC while bit7 is set.
  always @(posedge clk) begin
    if (sr_clr) begin
      sr    <= 8'h01;
      sr_dn <= 1'b0;
    end else if (sr_ena) begin
      if (!sr_dn) begin
        sr <= sr << 1;
        if (sr[6]) sr_dn <= 1'b1;
      end else begin
        sr <= sr >> 1;
        if (sr[1]) sr_dn <= 1'b0;
      end
    end
  end
  assign sr_tc = sr[7];

  typedef struct {
    logic [15:0] div;
    logic [7:0]  periods;
    int          hold_at;
    int          hold_len;
    int          exp_pulses;
    int          exp_pd;
  } row_t;

  row_t rows[4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic sr_clear();
    @(negedge clk); sr_clr = 1'b1;
    @(negedge clk); sr_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_row(input int idx, input row_t r);
    int c, pulses, last, gap_err, hold_err, post_err, done_c, d1;
    logic [7:0] pd_at_done;
    logic       busy_at_done;
    sr_clear();
    cfg_div = r.div;
    cfg_periods = r.periods;
    pulse_start();
    d1 = ((r.div == 0) ? 1 : int'(r.div)) + 1;
    c = 0; pulses = 0; last = -1; gap_err = 0; hold_err = 0; post_err = 0; done_c = -1;
    pd_at_done = '0; busy_at_done = 1'b1;
    while (done_c < 0 && c < 3000) begin
      hold = (r.hold_len > 0) && (c >= r.hold_at) && (c < r.hold_at + r.hold_len);
      if (sr_ena) begin
        pulses++;
        if (last < 0) begin
          if (c != d1) gap_err++;
        end else if ((c - last) != d1 && !(r.hold_len > 0 && (c - last) == d1 + r.hold_len)) begin
          gap_err++;
        end
        if (r.hold_len > 0 && c > r.hold_at && c <= r.hold_at + r.hold_len) hold_err++;
        last = c;
      end
      if (done) begin
        done_c = c;
        pd_at_done = periods_done;
        busy_at_done = busy;
      end
      @(negedge clk);
      c++;
    end
    hold = 1'b0;
    chk($sformatf("row%0d_done_seen", idx), done_c >= 0, 1);
    chk($sformatf("row%0d_pulses", idx), pulses, r.exp_pulses);
    chk($sformatf("row%0d_periods_done", idx), pd_at_done, r.exp_pd);
    chk($sformatf("row%0d_busy_at_done", idx), busy_at_done, 0);
    chk($sformatf("row%0d_spacing_errs", idx), gap_err, 0);
    if (r.hold_len > 0) chk($sformatf("row%0d_ena_in_hold", idx), hold_err, 0);
    for (int k = 0; k < 4; k++) begin
      if (done || sr_ena || busy) post_err++;
      @(negedge clk);
    end
    chk($sformatf("row%0d_quiet_after_done", idx), post_err, 0);
  endtask

  // Randomized run checked cycle by cycle against closed-form step/TC timing.
  task automatic run_random(input int idx);
    int d, p, n, dc, c, exp_pd, tc_k;
    logic exp_ena, exp_done, exp_busy;
    d = $urandom_range(0, 4);
    p = $urandom_range(0, 3);
    sr_clear();
    cfg_div = 16'(d);
    cfg_periods = 8'(p);
    pulse_start();
    if (d == 0) d = 1;
    n  = (p == 0) ? 0 : 7 + 14 * (p - 1);
    dc = (p == 0) ? 0 : n * (d + 1) + 2;
    for (c = 0; c <= dc + 3; c++) begin
      exp_ena  = (p > 0) && (c > 0) && (c % (d + 1) == 0) && (c / (d + 1) <= n);
      exp_done = (c == dc);
      exp_busy = (p > 0) && (c < dc);
      exp_pd = 0;
      for (int i = 1; i <= p; i++) begin
        tc_k = 7 + 14 * (i - 1);
        if (tc_k * (d + 1) + 2 <= c) exp_pd++;
      end
      chk($sformatf("rnd%0d_c%0d_sr_ena", idx, c), sr_ena, exp_ena);
      chk($sformatf("rnd%0d_c%0d_done", idx, c), done, exp_done);
      chk($sformatf("rnd%0d_c%0d_busy", idx, c), busy, exp_busy);
      chk($sformatf("rnd%0d_c%0d_periods_done", idx, c), periods_done, exp_pd);
      // Stray starts and config churn while running must be ignored.
      start = (c < dc) && ($urandom_range(0, 15) == 0);
      if (c < dc) begin
        cfg_div = 16'($urandom_range(0, 7));
        cfg_periods = 8'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, bad;
    logic seen;

    rows[0] = '{div: 16'd3, periods: 8'd2, hold_at: 0,  hold_len: 0,  exp_pulses: 21, exp_pd: 2};
    rows[1] = '{div: 16'd0, periods: 8'd1, hold_at: 0,  hold_len: 0,  exp_pulses: 7,  exp_pd: 1};
    rows[2] = '{div: 16'd5, periods: 8'd0, hold_at: 0,  hold_len: 0,  exp_pulses: 0,  exp_pd: 0};
    rows[3] = '{div: 16'd3, periods: 8'd5, hold_at: 30, hold_len: 20, exp_pulses: 63, exp_pd: 5};

    #2 rstna = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sr_ena", sr_ena, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_periods_done", periods_done, 0);
    rstna = 1'b1;
    sr_clr = 1'b0;

    for (int i = 0; i < 4; i++) run_row(i, rows[i]);

    // Abort lands on the cycle the final TC rise is visible.
    sr_clear();
    cfg_div = 16'd3;
    cfg_periods = 8'd1;
    pulse_start();
    seen = 1'b0;
    for (c = 0; c < 300 && !seen; c++) begin
      if (sr_tc) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort_tc_seen", seen, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sr_ena", sr_ena, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || sr_ena || busy) bad++;
      @(negedge clk);
    end
    chk("abort_no_done", bad, 0);

    // Start while running is ignored, then async reset mid-run clears everything.
    sr_clear();
    cfg_div = 16'd2;
    cfg_periods = 8'd3;
    pulse_start();
    for (c = 0; c < 300 && periods_done != 8'd1; c++) @(negedge clk);
    chk("rst_first_period", periods_done, 1);
    cfg_div = 16'd0;
    cfg_periods = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    chk("start_ignored_count", periods_done, 1);
    for (c = 0; c < 20 && !sr_ena; c++) @(negedge clk);
    chk("rst_ena_before", sr_ena, 1);
    #2 rstna = 1'b0;
    #1;
    chk("rst_mid_sr_ena", sr_ena, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_periods_done", periods_done, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rstna = 1'b1;

    for (int r = 0; r < 8; r++) run_random(r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
